// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Single data-memory port controller: arbitrates memory-FU loads against
// retired-store drains from the LSQ, tracks one outstanding access and
// squashes load writeback when a younger-than-branch load is flushed.
// Optional feature macro: DMEM_ARB_FAIRNESS_EN enables the load-streak
// counter that forces a waiting store through after MAX_LOAD_STREAK loads.
module dmem_port_arbiter #(
    parameter int MAX_LOAD_STREAK = 4,
    parameter int ROB_W           = 5,
    parameter int PD_W            = 7
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ld_req_valid,
    output logic             ld_req_ready,
    input  logic [31:0]      ld_addr,
    input  logic [PD_W-1:0]  ld_pd,
    input  logic [ROB_W-1:0] ld_rob,
    input  logic             st_req_valid,
    output logic             st_req_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic             lsq_full,
    output logic             mem_req_valid,
    input  logic             mem_req_ready,
    output logic             mem_req_we,
    output logic [31:0]      mem_req_addr,
    output logic [31:0]      mem_req_wdata,
    input  logic             mem_resp_valid,
    input  logic [31:0]      mem_resp_data,
    output logic             wb_valid,
    output logic [PD_W-1:0]  wb_pd,
    output logic [ROB_W-1:0] wb_rob,
    output logic [31:0]      wb_data,
    input  logic [ROB_W-1:0] rob_head,
    input  logic             mispredict,
    input  logic [ROB_W-1:0] mispredict_tag,
    output logic             busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // A zero streak limit would starve loads outright when a store waits.
    if (MAX_LOAD_STREAK < 1) begin : g_bad_streak
        $error("MAX_LOAD_STREAK must be at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic             squash_q, squash_d;
    logic             we_q;
    logic [31:0]      addr_q, wdata_q;
    logic [PD_W-1:0]  pd_q;
    logic [ROB_W-1:0] rob_q;
    logic             wb_valid_q, wb_valid_d;
    logic [PD_W-1:0]  wb_pd_q;
    logic [ROB_W-1:0] wb_rob_q;
    logic [31:0]      wb_data_q;

    logic             idle, in_req;
    logic             store_pri, st_win, st_go, ld_go;
    logic [ROB_W-1:0] ld_age, mp_age;
    logic             kill_ld;

    assign idle   = (state_q == S_IDLE);
    assign in_req = (state_q == S_REQ);

`ifdef DMEM_ARB_FAIRNESS_EN
    localparam int               STK_W   = $clog2(MAX_LOAD_STREAK + 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_LOAD_STREAK);

    logic [STK_W-1:0] streak_q, streak_d;

    // A waiting store wins once loads have used up their streak allowance.
    assign store_pri = lsq_full | (streak_q >= STK_MAX);

    // Streak counts loads that overtook a waiting store; any store grant resets it.
    always_comb begin
        streak_d = streak_q;
        if (st_go)
            streak_d = '0;
        else if (ld_go && st_req_valid && (streak_q != STK_MAX))
            streak_d = streak_q + 1'b1;
    end

    // Streak register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) streak_q <= '0;
        else          streak_q <= streak_d;
    end
`else
    // Without the fairness counter only a full LSQ lets a store beat a load.
    assign store_pri = lsq_full;
`endif

    // Store wins when alone or when it holds priority; loads also yield to a flush.
    assign st_win = st_req_valid & (~ld_req_valid | store_pri);
    assign st_go  = reset_n & idle & st_win;
    assign ld_go  = reset_n & idle & ld_req_valid & ~st_win & ~mispredict;

    assign ld_req_ready = ld_go;
    assign st_req_ready = st_go;

    // ROB ages are taken relative to the head so wraparound compares correctly.
    assign ld_age  = rob_q - rob_head;
    assign mp_age  = mispredict_tag - rob_head;
    assign kill_ld = mispredict & ~we_q & (ld_age > mp_age);

    // Access sequencing, squash tracking and writeback decision.
    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        wb_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                squash_d = 1'b0;
                if (st_go || ld_go) state_d = S_REQ;
            end
            S_REQ: begin
                // The request stays up even if squashed; only writeback is dropped.
                if (kill_ld) squash_d = 1'b1;
                if (mem_req_ready) begin
                    state_d = we_q ? S_IDLE : S_RESP;
                    if (we_q) squash_d = 1'b0;
                end
            end
            S_RESP: begin
                if (kill_ld) squash_d = 1'b1;
                if (mem_resp_valid) begin
                    state_d    = S_IDLE;
                    wb_valid_d = ~squash_q & ~kill_ld;
                    squash_d   = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                squash_d = 1'b0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            squash_q <= squash_d;
        end
    end

    // Capture the granted request so the memory channel sees stable fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pd_q    <= '0;
            rob_q   <= '0;
        end else if (st_go) begin
            we_q    <= 1'b1;
            addr_q  <= st_addr;
            wdata_q <= st_data;
        end else if (ld_go) begin
            we_q    <= 1'b0;
            addr_q  <= ld_addr;
            wdata_q <= '0;
            pd_q    <= ld_pd;
            rob_q   <= ld_rob;
        end
    end

    // Writeback pulse registered one cycle after the response arrives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_q <= 1'b0;
            wb_pd_q    <= '0;
            wb_rob_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            if (wb_valid_d) begin
                wb_pd_q   <= pd_q;
                wb_rob_q  <= rob_q;
                wb_data_q <= mem_resp_data;
            end
        end
    end

    assign mem_req_valid = in_req;
    assign mem_req_we    = in_req & we_q;
    assign mem_req_addr  = in_req ? addr_q  : '0;
    assign mem_req_wdata = in_req ? wdata_q : '0;

    assign wb_valid = wb_valid_q;
    assign wb_pd    = wb_pd_q;
    assign wb_rob   = wb_rob_q;
    assign wb_data  = wb_data_q;

    assign busy = ~idle;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: memory requests and writebacks are
// checked against scoreboard queues filled when stimulus is driven.
module tb_dmem_port_arbiter;

    localparam int ROB_W = 5;
    localparam int PD_W  = 7;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             ld_req_valid, ld_req_ready;
    logic [31:0]      ld_addr;
    logic [PD_W-1:0]  ld_pd;
    logic [ROB_W-1:0] ld_rob;
    logic             st_req_valid, st_req_ready;
    logic [31:0]      st_addr, st_data;
    logic             lsq_full;
    logic             mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]      mem_req_addr, mem_req_wdata;
    logic             mem_resp_valid;
    logic [31:0]      mem_resp_data;
    logic             wb_valid;
    logic [PD_W-1:0]  wb_pd;
    logic [ROB_W-1:0] wb_rob;
    logic [31:0]      wb_data;
    logic [ROB_W-1:0] rob_head;
    logic             mispredict;
    logic [ROB_W-1:0] mispredict_tag;
    logic             busy;

    dmem_port_arbiter #(.MAX_LOAD_STREAK(4), .ROB_W(ROB_W), .PD_W(PD_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
        .ld_addr(ld_addr), .ld_pd(ld_pd), .ld_rob(ld_rob),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
        .st_addr(st_addr), .st_data(st_data), .lsq_full(lsq_full),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .wb_valid(wb_valid), .wb_pd(wb_pd), .wb_rob(wb_rob), .wb_data(wb_data),
        .rob_head(rob_head), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [PD_W-1:0]  pd;
        logic [ROB_W-1:0] rob;
        logic [31:0]      data;
        int               cyc;
    } wb_t;

    req_t exp_req[$];
    wb_t  exp_wb[$];
    byte  glog[$];
    byte  exp_g[10];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    bit   fair_mode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sampled at the falling edge: grants, handshakes and writebacks.
    task automatic monitor();
        req_t r;
        wb_t  w;
        if (fair_mode) begin
            if (ld_req_ready) glog.push_back(8'h4C);
            if (st_req_ready) glog.push_back(8'h53);
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                chk("req_expected", exp_req.size() != 0, 1);
                if (exp_req.size() != 0) begin
                    r = exp_req.pop_front();
                    chk("req_we", mem_req_we, r.we);
                    chk("req_addr", mem_req_addr, r.addr);
                    chk("req_wdata", mem_req_wdata, r.wdata);
                end
            end
            if (wb_valid) begin
                chk("wb_expected", exp_wb.size() != 0, 1);
                if (exp_wb.size() != 0) begin
                    w = exp_wb.pop_front();
                    chk("wb_pd", wb_pd, w.pd);
                    chk("wb_rob", wb_rob, w.rob);
                    chk("wb_data", wb_data, w.data);
                    chk("wb_cycle", cyc_n, w.cyc);
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc_n++;
        #1;
    endtask

    // Full load: grant, handshake, lat-cycle response, optional flush in RESP.
    task automatic load_txn(input logic [31:0] a, input logic [PD_W-1:0] pd,
                            input logic [ROB_W-1:0] rob, input logic [31:0] d,
                            input int lat, input bit mp_en,
                            input logic [ROB_W-1:0] mp_tag, input bit want_wb);
        int n;
        ld_req_valid = 1'b1; ld_addr = a; ld_pd = pd; ld_rob = rob;
        mem_req_ready = 1'b1;
        #1;
        chk("ld_grant", ld_req_ready, 1);
        n = cyc_n;
        exp_req.push_back('{1'b0, a, 32'h0});
        if (want_wb) exp_wb.push_back('{pd, rob, d, n + 2 + lat});
        cyc();
        ld_req_valid = 1'b0;
        cyc();
        for (int i = 1; i < lat; i++) begin
            if (i == 1 && mp_en) begin
                mispredict = 1'b1; mispredict_tag = mp_tag;
            end
            cyc();
            mispredict = 1'b0;
        end
        mem_resp_valid = 1'b1; mem_resp_data = d;
        cyc();
        mem_resp_valid = 1'b0;
        cyc();
        cyc();
        chk("wb_drained", exp_wb.size(), 0);
        chk("idle_after_load", busy, 0);
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        ld_req_valid = 1'b1; ld_addr = '0; ld_pd = '0; ld_rob = '0;
        st_req_valid = 1'b1; st_addr = '0; st_data = '0; lsq_full = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        rob_head = '0; mispredict = 1'b0; mispredict_tag = '0;
        #3;
        chk("rst_ld_ready", ld_req_ready, 0);
        chk("rst_st_ready", st_req_ready, 0);
        chk("rst_mem_valid", mem_req_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        cyc();
        cyc();
        ld_req_valid = 1'b0; st_req_valid = 1'b0;
        reset_n = 1'b1;
        cyc();

        // Store only
        st_req_valid = 1'b1; st_addr = 32'h40; st_data = 32'hDEADBEEF;
        mem_req_ready = 1'b1;
        #1;
        chk("st_grant", st_req_ready, 1);
        chk("st_no_ld", ld_req_ready, 0);
        exp_req.push_back('{1'b1, 32'h40, 32'hDEADBEEF});
        cyc();
        st_req_valid = 1'b0;
        #1;
        chk("st_req_valid", mem_req_valid, 1);
        chk("st_req_we", mem_req_we, 1);
        chk("st_req_addr", mem_req_addr, 32'h40);
        chk("st_req_wdata", mem_req_wdata, 32'hDEADBEEF);
        cyc();
        chk("st_done_valid", mem_req_valid, 0);
        chk("st_done_busy", busy, 0);
        cyc();

        // Plain load, L=2
        load_txn(32'h40, 7'd12, 5'd3, 32'hDEADBEEF, 2, 1'b0, 5'd0, 1'b1);

        // Squash: head=30, load rob=2 (age 4); tag 0 (age 2) squashes, tag 5 (age 7) does not
        rob_head = 5'd30;
        load_txn(32'h44, 7'd20, 5'd2, 32'h1111, 2, 1'b1, 5'd0, 1'b0);
        load_txn(32'h48, 7'd21, 5'd2, 32'h2222, 2, 1'b1, 5'd5, 1'b1);
        rob_head = 5'd0;

        // Backpressure: 3 stall cycles then accept
        st_req_valid = 1'b1; st_addr = 32'h80; st_data = 32'h12345678;
        mem_req_ready = 1'b0;
        #1;
        chk("bp_grant", st_req_ready, 1);
        exp_req.push_back('{1'b1, 32'h80, 32'h12345678});
        cyc();
        ld_req_valid = 1'b1; ld_addr = 32'h90;
        for (int k = 0; k < 4; k++) begin
            mem_req_ready = (k == 3);
            #1;
            chk($sformatf("bp_valid%0d", k), mem_req_valid, 1);
            chk($sformatf("bp_we%0d", k), mem_req_we, 1);
            chk($sformatf("bp_addr%0d", k), mem_req_addr, 32'h80);
            chk($sformatf("bp_wdata%0d", k), mem_req_wdata, 32'h12345678);
            chk($sformatf("bp_ldrdy%0d", k), ld_req_ready, 0);
            chk($sformatf("bp_strdy%0d", k), st_req_ready, 0);
            cyc();
        end
        ld_req_valid = 1'b0; st_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("bp_idle", busy, 0);
        cyc();

        // Fairness: both valid continuously, responses always available
`ifdef DMEM_ARB_FAIRNESS_EN
        exp_g = '{8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h53, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h53};
`else
        exp_g = '{8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C, 8'h4C};
`endif
        glog.delete();
        fair_mode = 1'b1;
        ld_req_valid = 1'b1; st_req_valid = 1'b1; lsq_full = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'h5A5A;
        for (int t = 0; t < 200 && glog.size() < 10; t++) cyc();
        chk("fair_count", glog.size() >= 10, 1);
        if (glog.size() >= 10)
            for (int k = 0; k < 10; k++) chk($sformatf("fair_grant%0d", k), glog[k], exp_g[k]);
        lsq_full = 1'b1;
        base = glog.size();
        for (int t = 0; t < 50 && glog.size() <= base; t++) cyc();
        chk("lsq_full_seen", glog.size() > base, 1);
        if (glog.size() > base) chk("lsq_full_store", glog[base], 8'h53);
        ld_req_valid = 1'b0; st_req_valid = 1'b0; lsq_full = 1'b0;
        for (int t = 0; t < 4; t++) cyc();
        mem_resp_valid = 1'b0;
        cyc();
        cyc();
        fair_mode = 1'b0;
        chk("fair_drain_idle", busy, 0);

        // Async reset while waiting in RESP; late response must be ignored
        ld_req_valid = 1'b1; ld_addr = 32'h100; ld_pd = 7'd5; ld_rob = 5'd7;
        mem_req_ready = 1'b1;
        #1;
        chk("ar_grant", ld_req_ready, 1);
        exp_req.push_back('{1'b0, 32'h100, 32'h0});
        cyc();
        cyc();
        chk("ar_in_resp", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("ar_mem_valid", mem_req_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_wb_valid", wb_valid, 0);
        chk("ar_ld_ready", ld_req_ready, 0);
        cyc();
        reset_n = 1'b1; ld_req_valid = 1'b0;
        cyc();
        mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0BAD0;
        cyc();
        mem_resp_valid = 1'b0;
        cyc();
        cyc();
        chk("ar_late_idle", busy, 0);

        chk("req_queue_empty", exp_req.size(), 0);
        chk("wb_queue_empty", exp_wb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
